// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the two-port memory arbiter.
// Both mem_arbiter and rr_arb2 import this package.
package mem_pkg;

   localparam int AW_DEF        = 12;
   localparam int DW_DEF        = 32;
   localparam int MAX_BURST_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   // Ownership state that corresponds to a given winning requester.
   function automatic state_t own_state(input logic who);
      return who ? OWN1 : OWN0;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational winner selection for two requesters: round-robin from IDLE,
// burst-limited stickiness while one requester owns the memory.
module rr_arb2 import mem_pkg::*; #(
   parameter int MAX_BURST = MAX_BURST_DEF,
   parameter int CW        = $clog2(MAX_BURST) + 1
) (
   input  state_t          state,
   input  logic [CW-1:0]   count,
   input  logic            rr,
   input  logic            req0,
   input  logic            req1,
   output logic            win_valid,
   output logic            winner
);

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

   logic under_limit;

   assign under_limit = (count < MAX_CNT);

   always_comb begin
      win_valid = 1'b0;
      winner    = 1'b0;
      case (state)
         OWN0: begin
            // The owner keeps the memory unless the other side is waiting
            // and the owner has used up its burst allowance.
            if (req0 && (!req1 || under_limit)) begin
               win_valid = 1'b1;
               winner    = 1'b0;
            end else if (req1) begin
               win_valid = 1'b1;
               winner    = 1'b1;
            end
         end
         OWN1: begin
            if (req1 && (!req0 || under_limit)) begin
               win_valid = 1'b1;
               winner    = 1'b1;
            end else if (req0) begin
               win_valid = 1'b1;
               winner    = 1'b0;
            end
         end
         default: begin
            if (req0 && req1) begin
               win_valid = 1'b1;
               winner    = rr;
            end else if (req0 || req1) begin
               win_valid = 1'b1;
               winner    = req1;
            end
         end
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-write/async-read memory:
// burst-limited ownership FSM, address/data mux and one-cycle read return.
module mem_arbiter import mem_pkg::*; #(
   parameter int AW        = AW_DEF,
   parameter int DW        = DW_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       req0,
   input  logic                       req1,
   input  logic                       we0,
   input  logic                       we1,
   input  logic [AW-1:0]              addr0,
   input  logic [AW-1:0]              addr1,
   input  logic [DW-1:0]              wdata0,
   input  logic [DW-1:0]              wdata1,
   output logic                       gnt0,
   output logic                       gnt1,
   output logic                       rvalid0,
   output logic                       rvalid1,
   output logic [DW-1:0]              rdata0,
   output logic [DW-1:0]              rdata1,
   output logic [AW-1:0]              mem_a,
   output logic [DW-1:0]              mem_d,
   output logic                       mem_we,
   output logic [AW-1:0]              mem_dpra,
   input  logic [DW-1:0]              mem_dpo,
   output logic [1:0]                 dbg_state,
   output logic [$clog2(MAX_BURST):0] dbg_count,
   output logic                       dbg_rr
);

   localparam int            CW      = $clog2(MAX_BURST) + 1;
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

   // Handshake: a requester raises req_i with we/addr/wdata stable; the beat
   // is accepted in any cycle where gnt_i=1. Un-granted beats are not stored,
   // so the requester holds them (or drops req) until gnt_i arrives.

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          rr;
   logic          rr_nxt;
   logic          win_valid;
   logic          winner;
   logic          beat;
   logic          rd0;
   logic          rd1;

   rr_arb2 #(
      .MAX_BURST (MAX_BURST),
      .CW        (CW)
   ) u_arb (
      .state     (state),
      .count     (count),
      .rr        (rr),
      .req0      (req0),
      .req1      (req1),
      .win_valid (win_valid),
      .winner    (winner)
   );

   // Reset masks the grant combinationally so nothing is written or read.
   assign beat = rstn & win_valid;

   // State register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
         count <= '0;
         rr    <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         rr    <= rr_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = IDLE;
      count_nxt = '0;
      rr_nxt    = rr;
      if (beat) begin
         state_nxt = own_state(winner);
         rr_nxt    = ~winner;
         if (state == own_state(winner)) begin
            count_nxt = (count >= MAX_CNT) ? MAX_CNT : count + 1'b1;
         end else begin
            count_nxt = CW'(1);
         end
      end
   end

   // Output logic: grants and the memory mux
   always_comb begin
      gnt0     = beat & ~winner;
      gnt1     = beat & winner;
      mem_a    = '0;
      mem_d    = '0;
      mem_we   = 1'b0;
      if (beat) begin
         mem_a  = winner ? addr1  : addr0;
         mem_d  = winner ? wdata1 : wdata0;
         mem_we = winner ? we1    : we0;
      end
      mem_dpra = mem_a;
   end

   assign rd0 = gnt0 & ~we0;
   assign rd1 = gnt1 & ~we1;

   // Read return: async memory data is captured on the edge ending the beat.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         rvalid0 <= rd0;
         rvalid1 <= rd1;
         if (rd0) begin
            rdata0 <= mem_dpo;
         end
         if (rd1) begin
            rdata1 <= mem_dpo;
         end
      end
   end

   assign dbg_state = state;
   assign dbg_count = count;
   assign dbg_rr    = rr;

endmodule
